// File: rtl/axi_lite_pkt_sorter_if.sv
// AXI-Lite write-channel bundle (AW, W, B) for the packet sorter.
interface axi_lite_pkt_sorter_if;
    logic [7:0]  aw_addr;
    logic        aw_valid;
    logic        aw_ready;
    logic [31:0] w_data;
    logic        w_valid;
    logic        w_ready;
    logic [1:0]  b_resp;
    logic        b_valid;
    logic        b_ready;

    modport master (
        output aw_addr, aw_valid, w_data, w_valid, b_ready,
        input  aw_ready, w_ready, b_resp, b_valid
    );

    modport slave (
        input  aw_addr, aw_valid, w_data, w_valid, b_ready,
        output aw_ready, w_ready, b_resp, b_valid
    );
endinterface

// File: rtl/axi_lite_pkt_sorter.sv
// AXI-Lite write-only packet sorter: stage a word, commit it into one
// of NUM_CH first-word-fall-through queues selected by its channel byte.
module axi_lite_pkt_sorter #(
    parameter int         NUM_CH    = 4,
    parameter int         DEPTH     = 16,
    parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    axi_lite_pkt_sorter_if.slave  bus,
    output logic [32*NUM_CH-1:0]  out_data,
    output logic [NUM_CH-1:0]     out_valid,
    input  logic [NUM_CH-1:0]     out_ready,
    output logic [15:0]           accept_cnt,
    output logic [15:0]           drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [7:0] A_STAGE  = 8'h00;
    localparam logic [7:0] A_COMMIT = 8'h04;
    localparam logic [7:0] A_FLUSH  = 8'h08;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic [1:0]  state;
    logic        aw_held;
    logic        w_held;
    logic [7:0]  addr_q;
    logic [31:0] data_q;
    logic [31:0] staged;
    logic        staged_valid;
    logic        b_valid_q;
    logic [1:0]  b_resp_q;

    logic [31:0]   mem    [NUM_CH][DEPTH];
    logic [AW-1:0] rd_ptr [NUM_CH];
    logic [AW-1:0] wr_ptr [NUM_CH];
    logic [CW-1:0] occ    [NUM_CH];

    logic              exec;
    logic              is_stage;
    logic              is_commit;
    logic              is_flush;
    logic [7:0]        ch;
    logic              pkt_ok;
    logic              ch_full;
    logic              push_ok;
    logic [NUM_CH-1:0] push;
    logic [NUM_CH-1:0] pop;

    assign bus.aw_ready = (state == IDLE) && !aw_held;
    assign bus.w_ready  = (state == IDLE) && !w_held;
    assign bus.b_valid  = b_valid_q;
    assign bus.b_resp   = b_resp_q;

    assign exec      = (state == EXEC);
    assign is_stage  = (addr_q == A_STAGE);
    assign is_commit = (addr_q == A_COMMIT);
    assign is_flush  = (addr_q == A_FLUSH);
    assign ch        = staged[23:16];
    assign pkt_ok    = staged_valid && (staged[31:24] == SYNC_BYTE) &&
                       (ch < 8'(NUM_CH));

    // Fullness is judged on pre-pop occupancy, so a same-edge pop
    // never makes room for the push.
    always_comb begin
        ch_full = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch == 8'(c) && occ[c] == CW'(DEPTH)) ch_full = 1'b1;
        end
    end

    assign push_ok = exec && is_commit && pkt_ok && !ch_full;

    always_comb begin
        out_data  = '0;
        out_valid = '0;
        push      = '0;
        pop       = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            out_valid[c] = (occ[c] != '0);
            pop[c]       = out_valid[c] && out_ready[c];
            push[c]      = push_ok && (ch == 8'(c));
            if (out_valid[c]) out_data[32*c +: 32] = mem[c][rd_ptr[c]];
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (push[c]) mem[c][wr_ptr[c]] <= staged;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                occ[c]    <= '0;
            end
        end else if (exec && is_flush) begin
            for (int c = 0; c < NUM_CH; c++) begin
                rd_ptr[c] <= '0;
                wr_ptr[c] <= '0;
                occ[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
                if (push[c] && !pop[c])      occ[c] <= occ[c] + CW'(1);
                else if (!push[c] && pop[c]) occ[c] <= occ[c] - CW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            staged       <= '0;
            staged_valid <= 1'b0;
            b_valid_q    <= 1'b0;
            b_resp_q     <= OKAY;
            accept_cnt   <= '0;
            drop_cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.aw_valid && !aw_held) begin
                        addr_q  <= bus.aw_addr;
                        aw_held <= 1'b1;
                    end
                    if (bus.w_valid && !w_held) begin
                        data_q <= bus.w_data;
                        w_held <= 1'b1;
                    end
                    if (aw_held && w_held) state <= EXEC;
                end
                EXEC: begin
                    state     <= RESP;
                    b_valid_q <= 1'b1;
                    unique case (1'b1)
                        is_stage: begin
                            staged       <= data_q;
                            staged_valid <= 1'b1;
                            b_resp_q     <= OKAY;
                        end
                        is_commit: begin
                            staged_valid <= 1'b0;
                            if (push_ok) begin
                                b_resp_q <= OKAY;
                                if (accept_cnt != 16'hFFFF)
                                    accept_cnt <= accept_cnt + 16'd1;
                            end else begin
                                b_resp_q <= SLVERR;
                                if (drop_cnt != 16'hFFFF)
                                    drop_cnt <= drop_cnt + 16'd1;
                            end
                        end
                        is_flush: b_resp_q <= OKAY;
                        default:  b_resp_q <= SLVERR;
                    endcase
                end
                RESP: begin
                    if (bus.b_ready) begin
                        b_valid_q <= 1'b0;
                        aw_held   <= 1'b0;
                        w_held    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_lite_pkt_sorter.sv
// Bench for axi_lite_pkt_sorter: directed table, corner sequences and
// randomized traffic checked against a queue-based reference model.
module tb_axi_lite_pkt_sorter;
    localparam int NUM_CH = 4;
    localparam int DEPTH  = 16;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [32*NUM_CH-1:0] out_data;
    logic [NUM_CH-1:0]    out_valid;
    logic [NUM_CH-1:0]    out_ready;
    logic [15:0]          accept_cnt;
    logic [15:0]          drop_cnt;

    axi_lite_pkt_sorter_if bus ();

    axi_lite_pkt_sorter #(
        .NUM_CH(NUM_CH), .DEPTH(DEPTH), .SYNC_BYTE(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready),
        .accept_cnt(accept_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] mq [NUM_CH][$];
    logic [31:0] m_stg;
    logic        m_sv;
    int          m_acc;
    int          m_drop;

    typedef struct {
        logic [7:0]  a;
        logic [31:0] d;
        logic [1:0]  resp;
        logic [3:0]  vld;
        logic [15:0] acc;
        logic [15:0] drp;
    } vec_t;
    vec_t tv [11];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    function automatic void m_reset();
        for (int c = 0; c < NUM_CH; c++) mq[c].delete();
        m_stg  = '0;
        m_sv   = 1'b0;
        m_acc  = 0;
        m_drop = 0;
    endfunction

    // Reference: one register write plus the pops seen on its EXEC edge.
    function automatic logic [1:0] m_xact(input logic [7:0] a,
                                          input logic [31:0] d,
                                          input logic [NUM_CH-1:0] pm);
        logic [1:0] r;
        logic [NUM_CH-1:0] pops;
        int ch;
        for (int c = 0; c < NUM_CH; c++)
            pops[c] = pm[c] && (mq[c].size() > 0);
        r = OKAY;
        if (a == 8'h00) begin
            m_stg = d;
            m_sv  = 1'b1;
        end else if (a == 8'h04) begin
            ch = int'(m_stg[23:16]);
            if (m_sv && m_stg[31:24] == 8'hA5 && ch < NUM_CH &&
                mq[ch].size() < DEPTH) begin
                mq[ch].push_back(m_stg);
                if (m_acc < 65535) m_acc++;
            end else begin
                r = SLVERR;
                if (m_drop < 65535) m_drop++;
            end
            m_sv = 1'b0;
        end else if (a == 8'h08) begin
            for (int c = 0; c < NUM_CH; c++) mq[c].delete();
            pops = '0;
        end else begin
            r = SLVERR;
        end
        for (int c = 0; c < NUM_CH; c++)
            if (pops[c]) void'(mq[c].pop_front());
        return r;
    endfunction

    task automatic chk_outs(input string nm);
        logic [NUM_CH-1:0] ev;
        logic [31:0] ed;
        for (int c = 0; c < NUM_CH; c++) begin
            ev[c] = (mq[c].size() > 0);
            ed    = ev[c] ? mq[c][0] : 32'h0;
            chk($sformatf("%s_data%0d", nm, c),
                64'(out_data[32*c +: 32]), 64'(ed));
        end
        chk({nm, "_valid"}, 64'(out_valid), 64'(ev));
        chk({nm, "_acc"}, 64'(accept_cnt), 64'(m_acc));
        chk({nm, "_drop"}, 64'(drop_cnt), 64'(m_drop));
    endtask

    task automatic chk_reset(input string nm);
        chk({nm, "_aw_ready"}, 64'(bus.aw_ready), 64'(1));
        chk({nm, "_w_ready"}, 64'(bus.w_ready), 64'(1));
        chk({nm, "_b_valid"}, 64'(bus.b_valid), 64'(0));
        chk({nm, "_b_resp"}, 64'(bus.b_resp), 64'(0));
        chk({nm, "_out_valid"}, 64'(out_valid), 64'(0));
        chk({nm, "_out_data"}, 64'(out_data), 64'(0));
        chk({nm, "_acc"}, 64'(accept_cnt), 64'(0));
        chk({nm, "_drop"}, 64'(drop_cnt), 64'(0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk_reset("reset");
        rst = 1'b0;
        m_reset();
    endtask

    // lead > 0: W leads AW by lead cycles; lead < 0: AW leads W.
    task automatic do_wr(input logic [7:0] a, input logic [31:0] d,
                         input int lead, input int bdel,
                         input logic [NUM_CH-1:0] pm,
                         input bit rst_exec,
                         output logic [1:0] r, output int lat,
                         output bit stable);
        bit aw_done, w_done, hs_aw, hs_w;
        int k;
        aw_done = 0;
        w_done  = 0;
        r       = 2'b11;
        lat     = -1;
        stable  = 1;
        bus.b_ready = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            bus.aw_addr  = a;
            bus.w_data   = d;
            bus.aw_valid = !aw_done && cyc >= lead;
            bus.w_valid  = !w_done && cyc >= -lead;
            hs_aw = bus.aw_valid && bus.aw_ready;
            hs_w  = bus.w_valid && bus.w_ready;
            @(posedge clk);
            aw_done |= hs_aw;
            w_done  |= hs_w;
            if (aw_done && w_done) break;
        end
        @(negedge clk);
        bus.aw_valid = 1'b0;
        bus.w_valid  = 1'b0;
        chk("handshake", 64'({aw_done, w_done}), 64'(2'b11));
        if (!(aw_done && w_done)) return;
        k = 0;
        while (k < 12 && !bus.b_valid) begin
            if (k == 1) begin
                out_ready = pm;
                if (rst_exec) rst = 1'b1;
            end
            @(negedge clk);
            k++;
            if (k == 2) out_ready = '0;
            if (rst_exec && k == 2) return;
        end
        out_ready = '0;
        if (!bus.b_valid) return;
        lat = k;
        r   = bus.b_resp;
        for (int j = 0; j < bdel; j++) begin
            @(negedge clk);
            if (!bus.b_valid || bus.b_resp !== r) stable = 0;
        end
        bus.b_ready = 1'b1;
        @(negedge clk);
        bus.b_ready = 1'b0;
        if (bus.b_valid) stable = 0;
    endtask

    task automatic xact(input string nm, input logic [7:0] a,
                        input logic [31:0] d, input int lead,
                        input int bdel, input logic [NUM_CH-1:0] pm,
                        output logic [1:0] r);
        logic [1:0] er;
        int lat;
        bit st;
        do_wr(a, d, lead, bdel, pm, 1'b0, r, lat, st);
        er = m_xact(a, d, pm);
        chk({nm, "_resp"}, 64'(r), 64'(er));
        chk({nm, "_lat"}, 64'(lat), 64'(2));
        chk({nm, "_stable"}, 64'(st), 64'(1));
        chk_outs(nm);
    endtask

    task automatic pop(input logic [NUM_CH-1:0] m);
        @(negedge clk);
        out_ready = m;
        @(negedge clk);
        out_ready = '0;
        for (int c = 0; c < NUM_CH; c++)
            if (m[c] && mq[c].size() > 0) void'(mq[c].pop_front());
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [1:0]  r;
        logic [7:0]  a;
        logic [31:0] d;
        int lat, n, pick;
        bit st;

        tv[0]  = '{8'h00, 32'hA5010203, OKAY,   4'b0000, 16'd0, 16'd0};
        tv[1]  = '{8'h04, 32'h00000000, OKAY,   4'b0010, 16'd1, 16'd0};
        tv[2]  = '{8'h00, 32'hFF000001, OKAY,   4'b0010, 16'd1, 16'd0};
        tv[3]  = '{8'h04, 32'h00000000, SLVERR, 4'b0010, 16'd1, 16'd1};
        tv[4]  = '{8'h00, 32'hA5070000, OKAY,   4'b0010, 16'd1, 16'd1};
        tv[5]  = '{8'h04, 32'h00000000, SLVERR, 4'b0010, 16'd1, 16'd2};
        tv[6]  = '{8'h04, 32'h00000000, SLVERR, 4'b0010, 16'd1, 16'd3};
        tv[7]  = '{8'h0C, 32'h12345678, SLVERR, 4'b0010, 16'd1, 16'd3};
        tv[8]  = '{8'h00, 32'hA5030000, OKAY,   4'b0010, 16'd1, 16'd3};
        tv[9]  = '{8'h08, 32'h00000000, OKAY,   4'b0000, 16'd1, 16'd3};
        tv[10] = '{8'h04, 32'h00000000, OKAY,   4'b1000, 16'd2, 16'd3};

        bus.aw_addr  = '0;
        bus.aw_valid = 1'b0;
        bus.w_data   = '0;
        bus.w_valid  = 1'b0;
        bus.b_ready  = 1'b0;
        out_ready    = '0;
        m_reset();
        repeat (2) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_wr(tv[i].a, tv[i].d, 0, 0, '0, 1'b0, r, lat, st);
            void'(m_xact(tv[i].a, tv[i].d, '0));
            chk($sformatf("tv%0d_resp", i), 64'(r), 64'(tv[i].resp));
            chk($sformatf("tv%0d_valid", i), 64'(out_valid),
                64'(tv[i].vld));
            chk($sformatf("tv%0d_acc", i), 64'(accept_cnt),
                64'(tv[i].acc));
            chk($sformatf("tv%0d_drop", i), 64'(drop_cnt),
                64'(tv[i].drp));
            if (i == 1)
                chk("tv1_data1", 64'(out_data[63:32]), 64'(32'hA5010203));
        end
        chk("tv10_data3", 64'(out_data[127:96]), 64'(32'hA5030000));

        // W three cycles ahead of AW, slow b_ready.
        xact("wfirst", 8'h00, 32'hA5020042, 3, 5, '0, r);
        chk("wfirst_okay", 64'(r), 64'(OKAY));
        xact("awfirst", 8'h04, 32'h0, -2, 2, '0, r);
        chk("awfirst_okay", 64'(r), 64'(OKAY));

        // Fill channel 0, then overflow with and without a same-edge pop.
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            xact("fill_stg", 8'h00, 32'hA5000000 + 32'(i), 0, 0, '0, r);
            xact("fill_cmt", 8'h04, 32'h0, 0, 0, '0, r);
            chk("fill_okay", 64'(r), 64'(OKAY));
        end
        xact("ovf_stg", 8'h00, 32'hA5000010, 0, 0, '0, r);
        xact("ovf_cmt", 8'h04, 32'h0, 0, 0, '0, r);
        chk("ovf_slverr", 64'(r), 64'(SLVERR));
        xact("ovfpop_stg", 8'h00, 32'hA5000011, 0, 0, '0, r);
        xact("ovfpop_cmt", 8'h04, 32'h0, 0, 0, 4'b0001, r);
        chk("ovfpop_slverr", 64'(r), 64'(SLVERR));
        n = 0;
        while (out_valid[0] && n < 20) begin
            chk("drain_order", 64'(out_data[31:0]),
                64'(32'hA5000001 + 32'(n)));
            pop(4'b0001);
            n++;
        end
        chk("drain_count", 64'(n), 64'(15));

        // Flush, bad address, reset during EXEC.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            d = (i < 2) ? 32'hA5000100 + 32'(i) : 32'hA5020200 + 32'(i);
            xact("fl_stg", 8'h00, d, 0, 0, '0, r);
            xact("fl_cmt", 8'h04, 32'h0, 0, 0, '0, r);
        end
        chk("fl_prevalid", 64'(out_valid), 64'(4'b0101));
        xact("flush", 8'h08, 32'h0, 0, 0, '0, r);
        chk("flush_okay", 64'(r), 64'(OKAY));
        chk("flush_valid", 64'(out_valid), 64'(0));
        xact("badaddr", 8'h0C, 32'hA5000000, 0, 0, '0, r);
        chk("badaddr_slverr", 64'(r), 64'(SLVERR));
        xact("abort_stg", 8'h00, 32'hA5020001, 0, 0, '0, r);
        do_wr(8'h04, 32'h0, 0, 0, '0, 1'b1, r, lat, st);
        chk_reset("abort");
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        n = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.b_valid) n++;
        end
        chk("abort_no_resp", 64'(n), 64'(0));
        chk_outs("abort_after");

        // Randomized traffic against the reference model.
        for (int i = 0; i < 300; i++) begin
            pick = $urandom_range(0, 99);
            if (pick < 45)      a = 8'h00;
            else if (pick < 85) a = 8'h04;
            else if (pick < 88) a = 8'h08;
            else if (pick < 93) a = 8'h0C;
            else                a = 8'($urandom);
            d = {($urandom_range(0, 99) < 85) ? 8'hA5 : 8'($urandom),
                 8'($urandom_range(0, 5)), 16'($urandom)};
            xact("rnd", a, d, $urandom_range(0, 4) - 2,
                 $urandom_range(0, 2),
                 ($urandom_range(0, 9) < 3) ? 4'($urandom) : 4'b0000, r);
            if ($urandom_range(0, 1) == 1) begin
                pop(4'($urandom));
                chk_outs("rnd_pop");
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
